// File: rtl/cabac_bit_reader.sv
`timescale 1ns/1ps
// cabac_bit_reader
//   Byte-to-bit feeder for the CABAC arithmetic decoder. Payload bytes are queued in a
//   small FIFO, moved one per cycle into a 32-bit MSB-aligned bit buffer, and served as
//   MSB-first fields of 1..MAX_BITS bits per request. After the final byte of the slice
//   has entered the bit buffer, reads beyond the end are zero-padded and flagged.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset, clears all state
//   flush      synchronous clear of FIFO, bit buffer, eos and counters; wins over all
//   in_data    payload byte, bit 7 first in stream order
//   in_valid   in_data valid
//   in_last    in_data is the final byte of the slice
//   in_ready   FIFO can accept a byte this cycle
//   rd_req     consumer requests rd_num bits
//   rd_num     field width 1..MAX_BITS (0 = no-op)
//   rd_grant   request served this cycle (combinational)
//   rd_bits    granted field, right-aligned, zero when not granted
//   bit_avail  valid bits held in the bit buffer (0..32)
//   underrun   sticky: a grant consumed zero-pad bits
//   bits_used  total bits granted since reset/flush, wraps mod 2^32
module cabac_bit_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_BITS   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  input  logic                rd_req,
  input  logic [4:0]          rd_num,
  output logic                rd_grant,
  output logic [MAX_BITS-1:0] rd_bits,
  output logic [5:0]          bit_avail,
  output logic                underrun,
  output logic [31:0]         bits_used
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [5:0]  MaxBitsW = 6'(MAX_BITS);

  // FIFO entries carry {last, byte}
  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  logic [31:0] buf_q, buf_d;
  logic [5:0]  count_q, count_d;
  logic        eos_q;
  logic        last_seen_q;
  logic        underrun_q;
  logic [31:0] bits_used_q;

  logic          fifo_empty, fifo_full;
  logic          push, wr_en, pop;
  logic [8:0]    head;
  logic [5:0]    rd_num_w, consumed, remain;
  logic [MAX_BITS-1:0] top_bits;

  always_comb begin
    rd_num_w   = {1'b0, rd_num};
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head       = mem[rd_ptr_q[AW-1:0]];

    // Grant looks only at the current buffer; a byte refilled this cycle is not bypassed.
    rd_grant = rd_req && !flush && (rd_num != 5'd0) &&
               ((rd_num_w <= count_q) || (eos_q && fifo_empty));

    consumed = 6'd0;
    if (rd_grant) consumed = (rd_num_w > count_q) ? count_q : rd_num_w;
    remain = count_q - consumed;

    pop = !fifo_empty && (remain <= 6'd24);

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    in_ready = reset && !flush && (!fifo_full || pop);
    push     = in_valid && in_ready;
    // Bytes after the final slice byte are accepted but dropped.
    wr_en    = push && !last_seen_q;

    // Bits below count are kept zero, so the padded case needs no masking.
    buf_d   = buf_q << consumed;
    count_d = remain;
    if (pop) begin
      buf_d   = buf_d | ({head[7:0], 24'h0} >> remain);
      count_d = remain + 6'd8;
    end

    top_bits = buf_q[31 -: MAX_BITS];
    rd_bits  = '0;
    if (rd_grant) rd_bits = top_bits >> (MaxBitsW - rd_num_w);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      buf_q       <= '0;
      count_q     <= '0;
      eos_q       <= 1'b0;
      last_seen_q <= 1'b0;
      underrun_q  <= 1'b0;
      bits_used_q <= '0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      buf_q       <= '0;
      count_q     <= '0;
      eos_q       <= 1'b0;
      last_seen_q <= 1'b0;
      underrun_q  <= 1'b0;
      bits_used_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (push && in_last) last_seen_q <= 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (head[8]) eos_q <= 1'b1;
      end
      buf_q   <= buf_d;
      count_q <= count_d;
      if (rd_grant) begin
        bits_used_q <= bits_used_q + 32'(rd_num);
        if (rd_num_w > count_q) underrun_q <= 1'b1;
      end
    end
  end

  assign bit_avail = count_q;
  assign underrun  = underrun_q;
  assign bits_used = bits_used_q;

endmodule

// File: tb/tb_cabac_bit_reader.sv
`timescale 1ns/1ps
// Testbench for cabac_bit_reader: directed cases plus a random stream, with a bit-level
// scoreboard (bits queued on byte acceptance, popped and compared on each grant).
module tb_cabac_bit_reader;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic        rd_req, rd_grant;
  logic [4:0]  rd_num;
  logic [15:0] rd_bits;
  logic [5:0]  bit_avail;
  logic        underrun;
  logic [31:0] bits_used;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bit          sb_q[$];
  bit          sb_last;
  bit          sb_pad;
  logic [31:0] used_model;

  cabac_bit_reader #(.FIFO_DEPTH(4), .MAX_BITS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .rd_req    (rd_req),
    .rd_num    (rd_num),
    .rd_grant  (rd_grant),
    .rd_bits   (rd_bits),
    .bit_avail (bit_avail),
    .underrun  (underrun),
    .bits_used (bits_used)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle of stimulus; scoreboard updated from what the DUT accepted/granted.
  task automatic run_cycle(input logic v, input logic [7:0] d, input logic l,
                           input logic rq, input logic [4:0] n,
                           output logic acc, output logic gnt, output logic [15:0] bits);
    logic [15:0] exp;
    in_valid = v; in_data = d; in_last = l; rd_req = rq; rd_num = n;
    #1;
    acc  = v && in_ready;
    gnt  = rd_grant;
    bits = rd_bits;
    if (acc && !sb_last) begin
      for (int i = 7; i >= 0; i--) sb_q.push_back(d[i]);
    end
    if (acc && l) sb_last = 1'b1;
    if (gnt) begin
      if (int'(n) > sb_q.size()) begin
        check("pad_needs_eos", {31'b0, sb_last}, 32'd1);
        sb_pad = 1'b1;
      end
      exp = '0;
      for (int i = 0; i < int'(n); i++) begin
        exp = exp << 1;
        if (sb_q.size() > 0) exp[0] = sb_q.pop_front();
      end
      check("rd_bits", {16'b0, bits}, {16'b0, exp});
      used_model = used_model + 32'(n);
    end else begin
      check("rd_bits_idle", {16'b0, bits}, 32'd0);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0; rd_req = 1'b0;
  endtask

  task automatic wait_read(input string tag, input logic [4:0] n, output logic [15:0] bits);
    logic acc, gnt;
    bits = '0;
    for (int c = 0; c < 12; c++) begin
      run_cycle(1'b0, 8'h00, 1'b0, 1'b1, n, acc, gnt, bits);
      if (gnt) return;
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_flush(input logic rq, input logic [4:0] n);
    flush = 1'b1; rd_req = rq; rd_num = n; in_valid = 1'b0;
    #1;
    check("flush_no_grant", {31'b0, rd_grant}, 32'd0);
    tick();
    flush = 1'b0; rd_req = 1'b0;
    sb_q.delete();
    sb_last = 1'b0; sb_pad = 1'b0; used_model = '0;
  endtask

  initial begin
    logic        acc, gnt;
    logic [15:0] bits;
    int          cnt, sent;
    logic [7:0]  nd;
    bit          restored;

    reset = 1'b0; flush = 1'b0; in_data = 8'h5A; in_valid = 1'b1; in_last = 1'b0;
    rd_req = 1'b1; rd_num = 5'd1;
    sb_last = 1'b0; sb_pad = 1'b0; used_model = '0;

    // 1: reset held with traffic offered
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_grant", {31'b0, rd_grant}, 32'd0);
    check("rst_bit_avail", {26'b0, bit_avail}, 32'd0);
    check("rst_bits_used", bits_used, 32'd0);
    in_valid = 1'b0; rd_req = 1'b0;
    reset = 1'b1;
    tick();
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);
    check("rel_underrun", {31'b0, underrun}, 32'd0);

    // 2: 0xA5,0x3C read as 9 + 7 bits
    run_cycle(1'b1, 8'hA5, 1'b0, 1'b0, 5'd0, acc, gnt, bits);
    run_cycle(1'b1, 8'h3C, 1'b0, 1'b0, 5'd0, acc, gnt, bits);
    wait_read("t2_r9", 5'd9, bits);
    check("t2_bits9", {16'b0, bits}, 32'h14A);
    check("t2_avail7", {26'b0, bit_avail}, 32'd7);
    wait_read("t2_r7", 5'd7, bits);
    check("t2_bits7", {16'b0, bits}, 32'h3C);
    check("t2_used16", bits_used, 32'd16);

    // 3: back-pressure, 4 bytes in buffer + 4 in FIFO
    do_flush(1'b0, 5'd0);
    nd = 8'h10; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      run_cycle(1'b1, nd, 1'b0, 1'b0, 5'd0, acc, gnt, bits);
      if (!acc) break;
      cnt++; nd++;
    end
    check("t3_accepted", cnt, 32'd8);
    restored = 1'b0; cnt = 0;
    for (int c = 0; c < 16; c++) begin
      run_cycle(1'b1, nd, 1'b0, 1'b1, 5'd1, acc, gnt, bits);
      if (gnt) cnt++;
      if (acc) begin
        restored = 1'b1;
        break;
      end
    end
    check("t3_restored", {31'b0, restored}, 32'd1);
    check("t3_reads_to_restore", cnt, 32'd8);
    for (int c = 0; c < 40 && sb_q.size() > 0; c++) begin
      run_cycle(1'b0, 8'h00, 1'b0, 1'b1, 5'd8, acc, gnt, bits);
    end
    check("t3_drained", sb_q.size(), 32'd0);

    // 4: end-of-stream padding, then the same read without in_last
    do_flush(1'b0, 5'd0);
    run_cycle(1'b1, 8'hFF, 1'b1, 1'b0, 5'd0, acc, gnt, bits);
    wait_read("t4_r12", 5'd12, bits);
    check("t4_bits", {16'b0, bits}, 32'hFF0);
    check("t4_underrun", {31'b0, underrun}, 32'd1);
    run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, acc, gnt, bits);
    check("t4_sticky", {31'b0, underrun}, 32'd1);
    check("t4_used", bits_used, 32'd12);
    do_flush(1'b0, 5'd0);
    check("t4_flush_underrun", {31'b0, underrun}, 32'd0);
    run_cycle(1'b1, 8'hFF, 1'b0, 1'b0, 5'd0, acc, gnt, bits);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      run_cycle(1'b0, 8'h00, 1'b0, 1'b1, 5'd12, acc, gnt, bits);
      if (gnt) cnt++;
    end
    check("t4_stall", cnt, 32'd0);
    check("t4_stall_avail", {26'b0, bit_avail}, 32'd8);

    // 5: flush with data buffered and a request pending
    do_flush(1'b0, 5'd0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 8'hC3 + 8'(i), 1'b0, 1'b0, 5'd0, acc, gnt, bits);
    run_cycle(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, acc, gnt, bits);
    check("t5_pre_avail", {26'b0, bit_avail}, 32'd24);
    do_flush(1'b1, 5'd4);
    rd_req = 1'b1; rd_num = 5'd4;
    #1;
    check("t5_grant", {31'b0, rd_grant}, 32'd0);
    check("t5_avail", {26'b0, bit_avail}, 32'd0);
    check("t5_underrun", {31'b0, underrun}, 32'd0);
    check("t5_in_ready", {31'b0, in_ready}, 32'd1);
    check("t5_used", bits_used, 32'd0);
    tick();
    check("t5_still_empty", {31'b0, rd_grant}, 32'd0);
    rd_req = 1'b0;

    // 6: random stream of 1000 bytes with random gaps and widths
    do_flush(1'b0, 5'd0);
    sent = 0;
    for (int c = 0; c < 30000; c++) begin
      run_cycle((sent < 1000) && ($urandom_range(0, 3) != 0), 8'($urandom), sent == 999,
                1'($urandom_range(0, 1)), 5'($urandom_range(1, 16)), acc, gnt, bits);
      if (acc) sent++;
      if (sent == 1000 && sb_q.size() == 0) break;
    end
    check("t6_sent", sent, 32'd1000);
    check("t6_drained", sb_q.size(), 32'd0);
    check("t6_bits_used", bits_used, used_model);
    check("t6_underrun", {31'b0, underrun}, {31'b0, sb_pad});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
